// File: rtl/synth_voice.sv
// Single-voice synthesizer: phase-accumulator oscillator, ADSR envelope,
// 3-stage scaling pipeline and first-order PDM output.
module synth_voice #(
    parameter int CLKSPEED = 50_000_000,
    parameter int DATA_W   = 10,
    parameter int PHASE_W  = 24,
    parameter int ENV_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gate,
    input  logic [1:0]         wave_sel,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [ENV_W-1:0]   attack_step,
    input  logic [ENV_W-1:0]   decay_step,
    input  logic [ENV_W-1:0]   sustain_level,
    input  logic [ENV_W-1:0]   release_step,
    input  logic [15:0]        amp,
    output logic [DATA_W-1:0]  sample_out,
    output logic               dout,
    output logic [ENV_W-1:0]   env_out,
    output logic [2:0]         state_out,
    output logic               active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    logic [PHASE_W-1:0]      r_phase;
    logic                    r_gate_q;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ENV_W-1:0]        r_env;
    logic [ENV_W-1:0]        w_env_nxt;
    logic [DATA_W-1:0]       r_s1;
    logic [DATA_W-1:0]       r_s2;
    logic [DATA_W-1:0]       r_sample;
    logic [DATA_W:0]         r_acc;

    logic [DATA_W-1:0]       w_p;
    logic [DATA_W-1:0]       w_tri;
    logic [DATA_W-1:0]       w_wave;
    logic                    w_rise;
    logic [ENV_W:0]          w_att_sum;
    logic [ENV_W-1:0]        w_att_sat;
    logic [DATA_W+ENV_W-1:0] w_mul1;
    logic [DATA_W+15:0]      w_mul2;
    logic [DATA_W:0]         w_acc_sum;

    // Oscillator
    assign w_p   = r_phase[PHASE_W-1 -: DATA_W];
    assign w_tri = {w_p[DATA_W-2:0], 1'b0};

    always_comb begin
        w_wave = '0;
        case (wave_sel)
            2'd0:    w_wave = w_p;
            2'd1:    w_wave = w_p[DATA_W-1] ? '0 : {DATA_W{1'b1}};
            2'd2:    w_wave = w_p[DATA_W-1] ? ~w_tri : w_tri;
            default: w_wave = '0;
        endcase
    end

    // Envelope FSM; a gate rising edge retriggers from the current level
    assign w_rise    = gate & ~r_gate_q;
    assign w_att_sum = {1'b0, r_env} + {1'b0, attack_step};
    assign w_att_sat = w_att_sum[ENV_W] ? {ENV_W{1'b1}} : w_att_sum[ENV_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        if (w_rise) begin
            w_state_nxt = S_ATTACK;
            w_env_nxt   = w_att_sat;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_env_nxt = '0;
                end
                S_ATTACK: begin
                    if (!gate) begin
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_env_nxt = w_att_sat;
                        if (w_att_sat == {ENV_W{1'b1}})
                            w_state_nxt = S_DECAY;
                    end
                end
                S_DECAY: begin
                    if (!gate) begin
                        w_state_nxt = S_RELEASE;
                    end else if ((r_env <= sustain_level) ||
                                 ((r_env - sustain_level) <= decay_step)) begin
                        w_state_nxt = S_SUSTAIN;
                        w_env_nxt   = sustain_level;
                    end else begin
                        w_env_nxt = r_env - decay_step;
                    end
                end
                S_SUSTAIN: begin
                    if (!gate)
                        w_state_nxt = S_RELEASE;
                    else
                        w_env_nxt = sustain_level;
                end
                S_RELEASE: begin
                    if (r_env <= release_step) begin
                        w_state_nxt = S_IDLE;
                        w_env_nxt   = '0;
                    end else begin
                        w_env_nxt = r_env - release_step;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_env_nxt   = '0;
                end
            endcase
        end
    end

    // Full-precision products, truncated to the top bits
    assign w_mul1    = {{ENV_W{1'b0}}, r_s1} * {{DATA_W{1'b0}}, r_env};
    assign w_mul2    = {16'd0, r_s2} * {{DATA_W{1'b0}}, amp};
    assign w_acc_sum = {1'b0, r_acc[DATA_W-1:0]} + {1'b0, r_sample};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= '0;
            r_gate_q <= 1'b0;
            r_state  <= S_IDLE;
            r_env    <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_sample <= '0;
            r_acc    <= '0;
        end else begin
            r_phase  <= r_phase + phase_inc;
            r_gate_q <= gate;
            r_state  <= w_state_nxt;
            r_env    <= w_env_nxt;
            r_s1     <= w_wave;
            r_s2     <= w_mul1[DATA_W+ENV_W-1:ENV_W];
            r_sample <= w_mul2[DATA_W+15:16];
            r_acc    <= w_acc_sum;
        end
    end

    // The accumulator carry bit is the registered PDM output
    assign dout       = r_acc[DATA_W];
    assign sample_out = r_sample;
    assign env_out    = r_env;
    assign state_out  = r_state;
    assign active     = (r_state != S_IDLE);

endmodule

// File: tb/tb_synth_voice.sv
// Directed bench for synth_voice: ADSR, retrigger, waveforms, PDM, async reset,
// zero-step hold.
module tb_synth_voice;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gate = 1'b0;
    logic [1:0]  wave_sel = 2'd0;
    logic [23:0] phase_inc = '0;
    logic [15:0] attack_step = '0;
    logic [15:0] decay_step = '0;
    logic [15:0] sustain_level = '0;
    logic [15:0] release_step = '0;
    logic [15:0] amp = '0;
    logic [9:0]  sample_out;
    logic        dout;
    logic [15:0] env_out;
    logic [2:0]  state_out;
    logic        active;

    int total = 0;
    int bad = 0;

    synth_voice dut (
        .clk(clk), .rst(rst), .gate(gate), .wave_sel(wave_sel),
        .phase_inc(phase_inc), .attack_step(attack_step),
        .decay_step(decay_step), .sustain_level(sustain_level),
        .release_step(release_step), .amp(amp), .sample_out(sample_out),
        .dout(dout), .env_out(env_out), .state_out(state_out), .active(active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        gate = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({sample_out, dout, env_out, state_out, active} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got so=%h dout=%b env=%h st=%0d act=%b required all 0",
                     sample_out, dout, env_out, state_out, active);
        end
        do_reset();
    endtask

    task automatic test_adsr();
        logic [15:0] exp_env[12];
        logic [2:0]  exp_st[12];
        logic [15:0] rel_env[5];
        logic [2:0]  rel_st[5];
        exp_env = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hEFFF, 16'hDFFF,
                    16'hCFFF, 16'hBFFF, 16'hAFFF, 16'h9FFF, 16'h8FFF, 16'h8000};
        exp_st  = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
        rel_env = '{16'h8000, 16'h6000, 16'h4000, 16'h2000, 16'h0000};
        rel_st  = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd0};
        attack_step = 16'h4000; decay_step = 16'h1000;
        sustain_level = 16'h8000; release_step = 16'h2000;
        amp = 16'hFFFF; wave_sel = 2'd0; phase_inc = 24'h010000;
        gate = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (env_out !== exp_env[i] || state_out !== exp_st[i]) begin
                bad++;
                $display("FAIL adsr_rise[%0d]: got env=%h st=%0d required env=%h st=%0d",
                         i, env_out, state_out, exp_env[i], exp_st[i]);
            end
        end
        sustain_level = 16'h7000;
        tick();
        total++;
        if (env_out !== 16'h7000 || state_out !== 3'd3) begin
            bad++;
            $display("FAIL sustain_track: got env=%h st=%0d required env=7000 st=3", env_out, state_out);
        end
        sustain_level = 16'h8000;
        tick();
        gate = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (env_out !== rel_env[i] || state_out !== rel_st[i]) begin
                bad++;
                $display("FAIL adsr_release[%0d]: got env=%h st=%0d required env=%h st=%0d",
                         i, env_out, state_out, rel_env[i], rel_st[i]);
            end
        end
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL idle_active: got %b required 0", active);
        end
    endtask

    task automatic test_retrigger();
        bit idle_seen;
        gate = 1'b1;
        repeat (12) tick();
        gate = 1'b0;
        repeat (3) tick();
        total++;
        if (env_out !== 16'h4000 || state_out !== 3'd4) begin
            bad++;
            $display("FAIL retrig_setup: got env=%h st=%0d required env=4000 st=4", env_out, state_out);
        end
        gate = 1'b1;
        tick();
        total++;
        if (env_out !== 16'h8000 || state_out !== 3'd1) begin
            bad++;
            $display("FAIL retrig: got env=%h st=%0d required env=8000 st=1", env_out, state_out);
        end
        gate = 1'b0;
        idle_seen = 1'b0;
        for (int i = 0; i < 100 && !idle_seen; i++) begin
            tick();
            if (state_out == 3'd0) idle_seen = 1'b1;
        end
        total++;
        if (!idle_seen) begin
            bad++;
            $display("FAIL retrig_idle_timeout: got st=%0d required 0 within 100 cycles", state_out);
        end
    endtask

    task automatic test_waveforms();
        logic [9:0] prev;
        logic [9:0] tri_tab[4];
        int idx;
        tri_tab = '{10'h000, 10'h1FE, 10'h3FD, 10'h1FD};
        do_reset();
        attack_step = 16'hFFFF; decay_step = 16'h0000;
        sustain_level = 16'hFFFF; release_step = 16'hFFFF;
        amp = 16'hFFFF; phase_inc = 24'h800000; wave_sel = 2'd0;
        gate = 1'b1;
        repeat (8) tick();
        total++;
        if (env_out !== 16'hFFFF) begin
            bad++;
            $display("FAIL wave_env_sat: got %h required FFFF", env_out);
        end
        prev = sample_out;
        total++;
        if (prev !== 10'h000 && prev !== 10'h1FE) begin
            bad++;
            $display("FAIL saw_value: got %h required 000 or 1FE", prev);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (sample_out !== ((prev == 10'h000) ? 10'h1FE : 10'h000)) begin
                bad++;
                $display("FAIL saw_alt[%0d]: got %h after %h", i, sample_out, prev);
            end
            prev = sample_out;
        end
        wave_sel = 2'd1;
        repeat (4) tick();
        prev = sample_out;
        total++;
        if (prev !== 10'h000 && prev !== 10'h3FD) begin
            bad++;
            $display("FAIL square_value: got %h required 000 or 3FD", prev);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (sample_out !== ((prev == 10'h000) ? 10'h3FD : 10'h000)) begin
                bad++;
                $display("FAIL square_alt[%0d]: got %h after %h", i, sample_out, prev);
            end
            prev = sample_out;
        end
        wave_sel = 2'd2; phase_inc = 24'h400000;
        repeat (4) tick();
        idx = -1;
        for (int k = 0; k < 4; k++) if (sample_out === tri_tab[k]) idx = k;
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL tri_value: got %h required one of 000/1FE/3FD/1FD", sample_out);
            idx = 0;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            idx = (idx + 1) % 4;
            total++;
            if (sample_out !== tri_tab[idx]) begin
                bad++;
                $display("FAIL tri_seq[%0d]: got %h required %h", i, sample_out, tri_tab[idx]);
            end
        end
        wave_sel = 2'd3;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (sample_out !== 10'h000) begin
                bad++;
                $display("FAIL silence[%0d]: got %h required 000", i, sample_out);
            end
            tick();
        end
    endtask

    task automatic test_pdm();
        logic prev;
        int ones;
        do_reset();
        attack_step = 16'hFFFF; decay_step = 16'h0000;
        sustain_level = 16'hFFFF; release_step = 16'hFFFF;
        amp = 16'h8041; phase_inc = 24'h000000; wave_sel = 2'd1;
        gate = 1'b1;
        repeat (8) tick();
        total++;
        if (sample_out !== 10'h200) begin
            bad++;
            $display("FAIL pdm_level: got %h required 200", sample_out);
        end
        prev = dout;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (dout !== ~prev) begin
                bad++;
                $display("FAIL pdm_alt[%0d]: got %b required %b", i, dout, ~prev);
            end
            prev = dout;
        end
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (dout === 1'b1) ones++;
        end
        total++;
        if (ones != 512) begin
            bad++;
            $display("FAIL pdm_density: got %0d ones required 512", ones);
        end
        amp = 16'h0000;
        repeat (4) tick();
        total++;
        if (sample_out !== 10'h000) begin
            bad++;
            $display("FAIL pdm_amp0_sample: got %h required 000", sample_out);
        end
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (dout !== 1'b0) ones++;
        end
        total++;
        if (ones != 0) begin
            bad++;
            $display("FAIL pdm_amp0_dout: got %0d ones required 0", ones);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        attack_step = 16'h4000; decay_step = 16'h1000;
        sustain_level = 16'h8000; release_step = 16'h2000;
        amp = 16'hFFFF; wave_sel = 2'd0; phase_inc = 24'h123456;
        gate = 1'b1;
        repeat (20) tick();
        total++;
        if (state_out !== 3'd3 || env_out !== 16'h8000) begin
            bad++;
            $display("FAIL areset_setup: got st=%0d env=%h required st=3 env=8000", state_out, env_out);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({sample_out, dout, env_out, state_out, active} !== '0) begin
            bad++;
            $display("FAIL areset_async: got so=%h dout=%b env=%h st=%0d act=%b required all 0",
                     sample_out, dout, env_out, state_out, active);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (state_out !== 3'd1 || env_out !== 16'h4000) begin
            bad++;
            $display("FAIL areset_gate_held: got st=%0d env=%h required st=1 env=4000", state_out, env_out);
        end
    endtask

    task automatic test_zero_step();
        int errs;
        do_reset();
        attack_step = 16'h0000;
        gate = 1'b1;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (state_out !== 3'd1 || env_out !== 16'h0000) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL zero_step: %0d cycles off, last st=%0d env=%h required st=1 env=0000",
                     errs, state_out, env_out);
        end
        gate = 1'b0;
    endtask

    initial begin
        test_reset();
        test_adsr();
        test_retrigger();
        test_waveforms();
        test_pdm();
        test_async_reset();
        test_zero_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synth_voice.md
SYNTH_VOICE -- requirements
Module: synth_voice

Interface
REQ-001 Parameters SHALL be:
- CLKSPEED, default 50_000_000: clock rate in Hz, documentation only.
- DATA_W, default 10: sample width.
- PHASE_W, default 24: phase accumulator width.
- ENV_W, default 16: envelope width.

REQ-002 Ports SHALL be:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- gate  in  1  note on (1) / off (0), synchronous to clk.
- wave_sel  in  2  0 saw, 1 square, 2 triangle, 3 silence.
- phase_inc  in  PHASE_W  oscillator increment per cycle.
- attack_step  in  ENV_W  per-cycle envelope rise in ATTACK.
- decay_step  in  ENV_W  per-cycle fall in DECAY.
- sustain_level  in  ENV_W  SUSTAIN target.
- release_step  in  ENV_W  per-cycle fall in RELEASE.
- amp  in  16  master volume, unsigned.
- sample_out  out  DATA_W  enveloped, scaled sample, unsigned.
- dout  out  1  PDM bitstream of sample_out.
- env_out  out  ENV_W  current envelope value.
- state_out  out  3  FSM state code.
- active  out  1  high when state is not IDLE.

Function
REQ-003 Phase register SHALL add phase_inc every cycle, modulo 2^PHASE_W; p = top DATA_W bits of phase.
REQ-004 Wave value SHALL be:
- saw: p.
- square: all-ones when the MSB of p is 0, else 0.
- triangle: {p[DATA_W-2:0],0} when the MSB is 0, else the bitwise inverse of that value.
- silence: 0.
REQ-005 wave_sel and phase_inc changes SHALL take effect on the next edge; there SHALL be no phase reset on waveform change.
REQ-006 gate SHALL be registered into gate_q; a rising edge is gate=1 and gate_q=0 at a clock edge.
REQ-007 FSM states SHALL be IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5-7 SHALL go to IDLE.
REQ-008 On any rising edge of gate, in any state including ATTACK, the FSM SHALL go to ATTACK with env <= sat(env+attack_step); env is not cleared (retrigger).
REQ-009 ATTACK SHALL behave as follows:
- env <= min(env+attack_step, 2^ENV_W-1).
- On reaching the maximum, go to DECAY.
REQ-010 DECAY SHALL behave as follows:
- env <= max(env-decay_step, sustain_level).
- On reaching sustain_level, go to SUSTAIN.
- If env is already at or below sustain_level on entry, go directly to SUSTAIN with env <= sustain_level.
REQ-011 SUSTAIN SHALL set env <= sustain_level every cycle, tracking live changes.
REQ-012 With gate=0 in ATTACK, DECAY or SUSTAIN, the FSM SHALL go to RELEASE; the release step applies from the next cycle.
REQ-013 RELEASE SHALL behave as follows:
- env <= max(env-release_step, 0).
- On reaching 0, go to IDLE.
- A rising gate edge overrides per REQ-008.
REQ-014 A step input of 0 SHALL hold env and the state indefinitely; this is not an error.
REQ-015 IDLE SHALL hold env at 0.
REQ-016 Sample pipeline SHALL have 3 registered stages:
- s1 = wave.
- s2 = (s1 × env) >> ENV_W.
- sample_out = (s2 × amp) >> 16.
- Full-precision products, then truncation.
REQ-017 sample_out SHALL lag the phase register by exactly 3 cycles; env sampled at stage 2 SHALL be the env register value that cycle.
REQ-018 PDM SHALL use a DATA_W+1 bit accumulator:
- acc <= acc[DATA_W-1:0] + sample_out; dout <= carry of that sum.
- Ones density SHALL equal sample_out/2^DATA_W.
REQ-019 env_out and state_out SHALL be direct register outputs; active SHALL be combinational from state.

Reset
REQ-020 rst high SHALL immediately (asynchronously) clear:
- phase, gate_q, env, pipeline stages, acc, sample_out and dout to 0.
- state to IDLE.
REQ-021 On rst deassertion, the first edge SHALL evaluate the gate edge with gate_q=0; gate held high through reset SHALL start ATTACK on the first edge.
REQ-022 rst mid-note SHALL abandon the note with no release phase.

Verification (DATA_W=10, PHASE_W=24, ENV_W=16)
REQ-023 The bench SHALL cover these directed scenarios:
- ADSR: attack 0x4000, decay 0x1000, sustain 0x8000, release 0x2000; gate up -> env 0x4000, 0x8000, 0xC000, 0xFFFF (DECAY), 0xEFFF … 0x8FFF, 0x8000 (SUSTAIN); gate down -> 0x6000, 0x4000, 0x2000, 0x0000 with state IDLE.
- Retrigger: in RELEASE at env 0x4000, gate rises -> state ATTACK, env 0x8000 next cycle.
- Wrap and waveform: phase_inc 0x800000, env saturated, amp 0xFFFF -> saw stage-1 alternates 0x000/0x200; square alternates 0x3FF/0x000; silence -> sample_out 0 after 3 cycles.
- PDM: sample_out held at 0x200 -> dout alternates 0,1, exactly 512 ones per 1024 cycles; amp 0 -> dout constant 0.
- Reset: rst pulsed in SUSTAIN, asynchronously between edges -> all outputs 0 and state_out 0 before the next edge; gate held high -> ATTACK on the first edge after release.
- Zero step: attack_step 0 with gate high -> state ATTACK, env 0 held for 1000 cycles.
